// File: rtl/joybus_tx_frame_if.sv
`default_nettype none
// ============================================================================
// Module   : joybus_tx_frame_if
// Purpose  : Bundles the request, pad and status signals of joybus_tx_frame.
//            master = command sequencer / receiver side, slave = transmitter.
// Signals  : cmd_data[8*MAX_BYTES] frame (byte0 in the top byte, sent first)
//            cmd_len[LEN_W] byte count, cmd_vld request, stop_ctl stop type,
//            wait_rx response wait, rx_done receiver done,
//            jb_tx/jb_tx_oe pad level/enable, busy, tx_done, rx_timeout,
//            cmd_err status.
// Revision : 1.0 - initial release
// ============================================================================
interface joybus_tx_frame_if #(
    parameter int MAX_BYTES = 3
);
    localparam int LEN_W = $clog2(MAX_BYTES + 1);

    logic [8*MAX_BYTES-1:0] cmd_data;
    logic [LEN_W-1:0]       cmd_len;
    logic                   cmd_vld;
    logic                   stop_ctl;
    logic                   wait_rx;
    logic                   rx_done;
    logic                   jb_tx;
    logic                   jb_tx_oe;
    logic                   busy;
    logic                   tx_done;
    logic                   rx_timeout;
    logic                   cmd_err;

    modport master (
        output cmd_data, cmd_len, cmd_vld, stop_ctl, wait_rx, rx_done,
        input  jb_tx, jb_tx_oe, busy, tx_done, rx_timeout, cmd_err
    );

    modport slave (
        input  cmd_data, cmd_len, cmd_vld, stop_ctl, wait_rx, rx_done,
        output jb_tx, jb_tx_oe, busy, tx_done, rx_timeout, cmd_err
    );
endinterface
`default_nettype wire

// File: rtl/joybus_tx_frame.sv
`default_nettype none
// ============================================================================
// Module   : joybus_tx_frame
// Purpose  : Joybus frame transmitter. Serialises 1..MAX_BYTES bytes MSB-first
//            as 4-quarter bit cells, appends a console or controller stop bit,
//            releases the line and optionally waits for the receiver.
// Ports    : clk  - system clock
//            rst  - synchronous active-high reset
//            bus  - joybus_tx_frame_if.slave (request inputs, pad and status
//                   outputs; all outputs registered)
// Revision : 1.0 - initial release
// ============================================================================
module joybus_tx_frame #(
    parameter int MAX_BYTES  = 3,
    parameter int T_Q        = 24,
    parameter int T_STOP_HI  = 48,
    parameter int RX_TIMEOUT = 2400
) (
    input  wire logic           clk,
    input  wire logic           rst,
    joybus_tx_frame_if.slave    bus
);
    localparam int LEN_W     = $clog2(MAX_BYTES + 1);
    localparam int c_DATA_W  = 8 * MAX_BYTES;
    localparam int c_BIT_W   = LEN_W + 3;
    localparam int c_MAX_A   = (3 * T_Q > T_STOP_HI) ? 3 * T_Q : T_STOP_HI;
    localparam int c_CNT_MAX = (c_MAX_A > RX_TIMEOUT) ? c_MAX_A : RX_TIMEOUT;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    // Counter reload values: each phase lasts (load + 1) cycles.
    localparam logic [c_CNT_W-1:0] c_LD_Q   = c_CNT_W'(T_Q - 1);
    localparam logic [c_CNT_W-1:0] c_LD_2Q  = c_CNT_W'(2 * T_Q - 1);
    localparam logic [c_CNT_W-1:0] c_LD_3Q  = c_CNT_W'(3 * T_Q - 1);
    localparam logic [c_CNT_W-1:0] c_LD_HI  = c_CNT_W'(T_STOP_HI - 1);
    localparam logic [c_CNT_W-1:0] c_LD_RX  = c_CNT_W'(RX_TIMEOUT - 1);
    localparam logic [LEN_W-1:0]   c_MAX_LEN = LEN_W'(MAX_BYTES);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_BIT_LO   = 3'd1,
        S_BIT_HI   = 3'd2,
        S_STOP_LO  = 3'd3,
        S_STOP_HI  = 3'd4,
        S_RCV_WAIT = 3'd5
    } state_t;

    state_t                r_state,  w_state_nxt;
    logic [c_CNT_W-1:0]    r_cnt,    w_cnt_nxt;
    logic [c_DATA_W-1:0]   r_shift,  w_shift_nxt;
    logic [c_BIT_W-1:0]    r_bit,    w_bit_nxt;
    logic [c_BIT_W-1:0]    r_last,   w_last_nxt;
    logic                  r_stop,   w_stop_nxt;
    logic                  r_wait,   w_wait_nxt;
    logic                  r_jb_tx,  w_jb_tx_nxt;
    logic                  r_oe,     w_oe_nxt;
    logic                  r_busy,   w_busy_nxt;
    logic                  r_tx_done, w_tx_done_nxt;
    logic                  r_rx_to,  w_rx_to_nxt;
    logic                  r_err,    w_err_nxt;
    logic                  w_len_ok;
    logic                  w_cnt_zero;

    assign w_len_ok   = (bus.cmd_len != '0) && (bus.cmd_len <= c_MAX_LEN);
    assign w_cnt_zero = (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_shift   <= '0;
            r_bit     <= '0;
            r_last    <= '0;
            r_stop    <= 1'b0;
            r_wait    <= 1'b0;
            r_jb_tx   <= 1'b1;
            r_oe      <= 1'b0;
            r_busy    <= 1'b0;
            r_tx_done <= 1'b0;
            r_rx_to   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_shift   <= w_shift_nxt;
            r_bit     <= w_bit_nxt;
            r_last    <= w_last_nxt;
            r_stop    <= w_stop_nxt;
            r_wait    <= w_wait_nxt;
            r_jb_tx   <= w_jb_tx_nxt;
            r_oe      <= w_oe_nxt;
            r_busy    <= w_busy_nxt;
            r_tx_done <= w_tx_done_nxt;
            r_rx_to   <= w_rx_to_nxt;
            r_err     <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_shift_nxt   = r_shift;
        w_bit_nxt     = r_bit;
        w_last_nxt    = r_last;
        w_stop_nxt    = r_stop;
        w_wait_nxt    = r_wait;
        w_tx_done_nxt = 1'b0;
        w_rx_to_nxt   = 1'b0;
        w_err_nxt     = 1'b0;

        case (r_state)
            S_IDLE: begin
                // The tx_done cycle still belongs to the finished frame, so a
                // request presented then is not taken.
                if (bus.cmd_vld && !r_tx_done) begin
                    if (w_len_ok) begin
                        w_state_nxt = S_BIT_LO;
                        w_shift_nxt = bus.cmd_data;
                        w_bit_nxt   = '0;
                        // Index of the last bit is 8*len-1.
                        w_last_nxt  = {bus.cmd_len - LEN_W'(1), 3'b111};
                        w_stop_nxt  = bus.stop_ctl;
                        w_wait_nxt  = bus.wait_rx;
                        w_cnt_nxt   = bus.cmd_data[c_DATA_W-1] ? c_LD_Q : c_LD_3Q;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            S_BIT_LO: begin
                if (w_cnt_zero) begin
                    w_state_nxt = S_BIT_HI;
                    w_cnt_nxt   = r_shift[c_DATA_W-1] ? c_LD_3Q : c_LD_Q;
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_W'(1);
                end
            end
            S_BIT_HI: begin
                if (w_cnt_zero) begin
                    if (r_bit == r_last) begin
                        w_state_nxt = S_STOP_LO;
                        w_cnt_nxt   = r_stop ? c_LD_2Q : c_LD_Q;
                    end else begin
                        // Low time of the next cell depends on the bit that
                        // moves into the MSB position.
                        w_state_nxt = S_BIT_LO;
                        w_shift_nxt = r_shift << 1;
                        w_bit_nxt   = r_bit + c_BIT_W'(1);
                        w_cnt_nxt   = r_shift[c_DATA_W-2] ? c_LD_Q : c_LD_3Q;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_W'(1);
                end
            end
            S_STOP_LO: begin
                if (w_cnt_zero) begin
                    w_state_nxt = S_STOP_HI;
                    w_cnt_nxt   = c_LD_HI;
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_W'(1);
                end
            end
            S_STOP_HI: begin
                if (w_cnt_zero) begin
                    w_tx_done_nxt = 1'b1;
                    if (r_wait) begin
                        w_state_nxt = S_RCV_WAIT;
                        w_cnt_nxt   = c_LD_RX;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_W'(1);
                end
            end
            S_RCV_WAIT: begin
                // rx_done takes priority over an expiring timeout.
                if (bus.rx_done) begin
                    w_state_nxt = S_IDLE;
                end else if (w_cnt_zero) begin
                    w_rx_to_nxt = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Pad outputs are registered copies of the next-state decode so they
        // change on the same edge as the state.
        w_jb_tx_nxt = !((w_state_nxt == S_BIT_LO) || (w_state_nxt == S_STOP_LO));
        w_oe_nxt    = (w_state_nxt == S_BIT_LO)  || (w_state_nxt == S_BIT_HI) ||
                      (w_state_nxt == S_STOP_LO) || (w_state_nxt == S_STOP_HI);
        w_busy_nxt  = (w_state_nxt != S_IDLE);
    end

    assign bus.jb_tx      = r_jb_tx;
    assign bus.jb_tx_oe   = r_oe;
    assign bus.busy       = r_busy;
    assign bus.tx_done    = r_tx_done;
    assign bus.rx_timeout = r_rx_to;
    assign bus.cmd_err    = r_err;

endmodule
`default_nettype wire
